binary_search_engine: RTL and testbench



---
 rtl/bsearch_pkg.sv | 15 +
 rtl/binary_search_engine_if.sv | 28 ++
 rtl/bsearch_fsm.sv | 62 ++++++
 rtl/binary_search_engine.sv | 134 +++++++++++++
 tb/tb_binary_search_engine.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bsearch_pkg.sv
// Shared types for the binary search engine: FSM state encoding and search mode values.
package bsearch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    COMPARE,
    DONE
  } state_t;

  localparam logic MODE_EXACT = 1'b0;
  localparam logic MODE_LOWER = 1'b1;

endpackage

// File: rtl/binary_search_engine_if.sv
// Request/result handshake plus RAM read port of the search engine, bundled as one interface.
interface binary_search_engine_if #(
  parameter int VAL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 5
) ();

  logic                  start;
  logic [VAL_WIDTH-1:0]  target;
  logic                  mode;
  logic                  busy;
  logic                  done;
  logic                  found;
  logic [ADDR_WIDTH:0]   result_addr;
  logic [ADDR_WIDTH:0]   probes;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [VAL_WIDTH-1:0]  mem_rdata;

  modport slave (
    input  start, target, mode, mem_rdata,
    output busy, done, found, result_addr, probes, mem_addr
  );

  modport master (
    output start, target, mode, mem_rdata,
    input  busy, done, found, result_addr, probes, mem_addr
  );

endinterface

// File: rtl/bsearch_fsm.sv
// Search control FSM with the read-latency wait counter; a probe costs RD_LATENCY+2 cycles.
// start is only honoured in IDLE; busy/done decode directly from the state register.
module bsearch_fsm
  import bsearch_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   start_i,
  input  logic   empty_i,
  input  logic   exact_hit_i,
  output state_t state_o,
  output logic   busy_o,
  output logic   done_o
);

  localparam int CW = $clog2(RD_LATENCY + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    if (start_i) state_d = ISSUE;
      ISSUE: begin
        if (empty_i) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          cnt_d   = CW'(RD_LATENCY);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = COMPARE;
      end
      COMPARE: state_d = exact_hit_i ? DONE : ISSUE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    state_o = state_q;
    busy_o  = (state_q != IDLE);
    done_o  = (state_q == DONE);
  end

endmodule

// File: rtl/binary_search_engine.sv
// Binary search over an external ascending-sorted sync-read RAM, exact or lower-bound mode.
// Interval is half-open [lo,hi); results are registered on the way into DONE so they are valid with done.
module binary_search_engine
  import bsearch_pkg::*;
#(
  parameter int VAL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int RD_LATENCY = 1
) (
  input logic                   clock,
  input logic                   reset_n,
  binary_search_engine_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_t                state;
  logic                  busy, done;
  logic                  empty, exact_hit;

  logic [VAL_WIDTH-1:0]  target_q, target_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH:0]   lo_q, lo_d, hi_q, hi_d, mid_q, mid_d;
  logic                  hit_q, hit_d;
  logic                  found_q, found_d;
  logic [ADDR_WIDTH:0]   result_q, result_d;
  logic [ADDR_WIDTH:0]   probes_q, probes_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic [ADDR_WIDTH+1:0] sum;
  logic [ADDR_WIDTH:0]   mid;

  // One extra bit on the sum keeps lo+hi exact even when hi == DEPTH.
  assign sum       = {1'b0, lo_q} + {1'b0, hi_q};
  assign mid       = (ADDR_WIDTH + 1)'(sum >> 1);
  assign empty     = (lo_q >= hi_q);
  assign exact_hit = (state == COMPARE) && (bus.mem_rdata == target_q) && (mode_q == MODE_EXACT);

  bsearch_fsm #(.RD_LATENCY(RD_LATENCY)) u_fsm (
    .clock       (clock),
    .reset_n     (reset_n),
    .start_i     (bus.start),
    .empty_i     (empty),
    .exact_hit_i (exact_hit),
    .state_o     (state),
    .busy_o      (busy),
    .done_o      (done)
  );

  always_comb begin
    target_d = target_q;
    mode_d   = mode_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    mid_d    = mid_q;
    hit_d    = hit_q;
    found_d  = found_q;
    result_d = result_q;
    probes_d = probes_q;
    addr_d   = addr_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          target_d = bus.target;
          mode_d   = bus.mode;
          lo_d     = '0;
          hi_d     = (ADDR_WIDTH + 1)'(DEPTH);
          hit_d    = 1'b0;
          found_d  = 1'b0;
          probes_d = '0;
        end
      end
      ISSUE: begin
        if (empty) begin
          result_d = lo_q;
          found_d  = (mode_q == MODE_LOWER) && hit_q;
        end else begin
          addr_d   = mid[ADDR_WIDTH-1:0];
          mid_d    = mid;
          probes_d = probes_q + 1'b1;
        end
      end
      COMPARE: begin
        if (bus.mem_rdata < target_q) begin
          lo_d = mid_q + 1'b1;
        end else if (bus.mem_rdata > target_q) begin
          hi_d = mid_q;
        end else if (mode_q == MODE_EXACT) begin
          found_d  = 1'b1;
          result_d = mid_q;
        end else begin
          // Lower-bound keeps narrowing left to reach the first equal entry.
          hit_d = 1'b1;
          hi_d  = mid_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      target_q <= '0;
      mode_q   <= MODE_EXACT;
      lo_q     <= '0;
      hi_q     <= '0;
      mid_q    <= '0;
      hit_q    <= 1'b0;
      found_q  <= 1'b0;
      result_q <= '0;
      probes_q <= '0;
      addr_q   <= '0;
    end else begin
      target_q <= target_d;
      mode_q   <= mode_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      mid_q    <= mid_d;
      hit_q    <= hit_d;
      found_q  <= found_d;
      result_q <= result_d;
      probes_q <= probes_d;
      addr_q   <= addr_d;
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.found       = found_q;
  assign bus.result_addr = result_q;
  assign bus.probes      = probes_q;
  assign bus.mem_addr    = addr_q;

endmodule

// File: tb/tb_binary_search_engine.sv
// Two engines (read latency 1 and 3) share one sorted memory and stimulus; a scoreboard per engine.
module tb_binary_search_engine;
  import bsearch_pkg::*;

  localparam int VW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  typedef struct packed {
    logic          found;
    logic [AW:0]   result;
    logic [AW:0]   probes;
    logic          early;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  binary_search_engine_if #(.VAL_WIDTH(VW), .ADDR_WIDTH(AW)) b1 ();
  binary_search_engine_if #(.VAL_WIDTH(VW), .ADDR_WIDTH(AW)) b3 ();

  binary_search_engine #(.VAL_WIDTH(VW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b1)
  );
  binary_search_engine #(.VAL_WIDTH(VW), .ADDR_WIDTH(AW), .RD_LATENCY(3)) dut3 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b3)
  );

  logic [VW-1:0] mem [DEPTH];
  logic [VW-1:0] p1;
  logic [VW-1:0] p3 [3];

  always @(posedge clock) begin
    p1    <= mem[b1.mem_addr];
    p3[0] <= mem[b3.mem_addr];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b1.mem_rdata = p1;
  assign b3.mem_rdata = p3[2];

  int   total = 0;
  int   bad   = 0;
  exp_t q1[$];
  exp_t q3[$];
  int   path[$];
  int   kk[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: results from plain counting over the array, probe path from a textbook search loop.
  function automatic void model(input logic [VW-1:0] t, input logic m, output exp_t e);
    int lo, hi, mid, n_lt;
    bit any;
    lo = 0; hi = DEPTH; n_lt = 0; any = 0;
    path.delete();
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] < t) n_lt++;
      if (mem[i] == t) any = 1;
    end
    e.found  = any;
    e.result = (AW + 1)'(n_lt);
    e.early  = 1'b0;
    while (lo < hi) begin
      mid = (lo + hi) / 2;
      path.push_back(mid);
      if (mem[mid] < t) lo = mid + 1;
      else if (mem[mid] > t) hi = mid;
      else if (m == MODE_EXACT) begin
        e.early  = 1'b1;
        e.result = (AW + 1)'(mid);
        break;
      end else hi = mid;
    end
    e.probes = (AW + 1)'(path.size());
  endfunction

  task automatic mon(input int idx, input int lat, input logic busy, input logic done,
                     input logic found, input logic [AW:0] ra, input logic [AW:0] pr,
                     input logic [AW-1:0] ma);
    exp_t e;
    int   j, r, qs;
    if (!reset_n || !busy) kk[idx] = 0;
    else kk[idx]++;
    if (kk[idx] > 0) begin
      j = (kk[idx] - 1) / (lat + 2);
      r = (kk[idx] - 1) % (lat + 2);
      if (r >= 1 && j < path.size()) chk($sformatf("mem_addr_L%0d", lat), 32'(ma), 32'(path[j]));
    end
    if (done) begin
      qs = (idx == 0) ? q1.size() : q3.size();
      if (qs == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done_L%0d: got done=1 required no done", lat);
      end else begin
        if (idx == 0) e = q1.pop_front();
        else e = q3.pop_front();
        chk($sformatf("found_L%0d", lat), 32'(found), 32'(e.found));
        chk($sformatf("result_L%0d", lat), 32'(ra), 32'(e.result));
        chk($sformatf("probes_L%0d", lat), 32'(pr), 32'(e.probes));
        chk($sformatf("latency_L%0d", lat), 32'(kk[idx]),
            32'(1 + int'(e.probes) * (lat + 2) + (e.early ? 0 : 1)));
      end
    end
  endtask

  always @(negedge clock) mon(0, 1, b1.busy, b1.done, b1.found, b1.result_addr, b1.probes, b1.mem_addr);
  always @(negedge clock) mon(1, 3, b3.busy, b3.done, b3.found, b3.result_addr, b3.probes, b3.mem_addr);

  task automatic drive(input logic s, input logic [VW-1:0] t, input logic m);
    b1.start = s; b1.target = t; b1.mode = m;
    b3.start = s; b3.target = t; b3.mode = m;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(q1.size() == 0 && q3.size() == 0 && !b1.busy && !b3.busy) && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (n >= 500) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got pending=%0d/%0d required 0/0", q1.size(), q3.size());
      q1.delete();
      q3.delete();
    end
  endtask

  // extra: 0 plain, 1 extra start while busy, 2 extra start in the done cycle of the latency-1 engine
  task automatic run(input logic [VW-1:0] t, input logic m, input int extra);
    exp_t e;
    int   n;
    model(t, m, e);
    q1.push_back(e);
    q3.push_back(e);
    @(posedge clock); #1;
    drive(1'b1, t, m);
    @(posedge clock); #1;
    drive(1'b0, '0, 1'b0);
    if (extra == 1) begin
      repeat (3) @(posedge clock);
      #1 drive(1'b1, 8'd1, MODE_EXACT);
      @(posedge clock); #1;
      drive(1'b0, '0, 1'b0);
    end else if (extra == 2) begin
      n = 0;
      while (!b1.done && n < 200) begin
        @(negedge clock);
        n++;
      end
      if (!b1.done) begin
        total++;
        bad++;
        $display("FAIL done_timeout: got done=0 required done=1");
      end else begin
        drive(1'b1, 8'd1, MODE_EXACT);
        @(posedge clock); #1;
        drive(1'b0, '0, 1'b0);
      end
    end
    wait_idle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy1"},   32'(b1.busy),        0);
    chk({tag, "_done1"},   32'(b1.done),        0);
    chk({tag, "_found1"},  32'(b1.found),       0);
    chk({tag, "_result1"}, 32'(b1.result_addr), 0);
    chk({tag, "_probes1"}, 32'(b1.probes),      0);
    chk({tag, "_addr1"},   32'(b1.mem_addr),    0);
    chk({tag, "_busy3"},   32'(b3.busy),        0);
    chk({tag, "_done3"},   32'(b3.done),        0);
    chk({tag, "_found3"},  32'(b3.found),       0);
    chk({tag, "_result3"}, 32'(b3.result_addr), 0);
    chk({tag, "_probes3"}, 32'(b3.probes),      0);
    chk({tag, "_addr3"},   32'(b3.mem_addr),    0);
  endtask

  task automatic fill_odd();
    for (int i = 0; i < DEPTH; i++) mem[i] = VW'(2 * i + 1);
  endtask

  initial begin
    int v;
    drive(1'b0, '0, 1'b0);
    fill_odd();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 chk_zero("reset");
    reset_n = 1'b1;

    // odd values: exact hit, miss in the middle, below everything, above everything
    run(8'd51, MODE_EXACT, 1);
    run(8'd50, MODE_EXACT, 0);
    run(8'd0,  MODE_EXACT, 2);
    run(8'd64, MODE_EXACT, 0);
    run(8'd64, MODE_LOWER, 0);
    run(8'd1,  MODE_LOWER, 0);

    // duplicates: value i/4
    for (int i = 0; i < DEPTH; i++) mem[i] = VW'(i / 4);
    run(8'd3, MODE_LOWER, 0);
    run(8'd3, MODE_EXACT, 0);
    run(8'd0, MODE_LOWER, 0);
    run(8'd9, MODE_LOWER, 0);

    // abort in WAIT: outputs clear at once and no done follows
    fill_odd();
    @(posedge clock); #1;
    drive(1'b1, 8'd51, MODE_EXACT);
    @(posedge clock); #1;
    drive(1'b0, '0, 1'b0);
    @(posedge clock); #2;
    reset_n = 1'b0;
    q1.delete();
    q3.delete();
    #1 chk_zero("abort");
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    run(8'd51, MODE_EXACT, 0);

    // randomized sorted contents and targets
    for (int blk = 0; blk < 6; blk++) begin
      v = $urandom_range(0, 20);
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] = VW'(v);
        v += $urandom_range(0, 3);
      end
      for (int s = 0; s < 8; s++)
        run(VW'($urandom_range(0, int'(mem[DEPTH-1]) + 2)), 1'($urandom_range(0, 1)), 0);
    end

    repeat (4) @(posedge clock);
    chk("pending_L1", 32'(q1.size()), 0);
    chk("pending_L3", 32'(q3.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
